iob_native_mem_ctrl: RTL

Back-end memory controller for the cache's native memory interface. It sits directly downstream of `iob_cache` and consumes the `mem_addr/mem_wdata/mem_wstrb/mem_valid` requests the cache produces on line fills and write-through. It answers each request from an internal byte-enabled word RAM, with `mem_rdata/mem_ready` after a programmable, deterministic latency. It replaces the one-cycle `mem_ready <= mem_valid` RAM model and exposes per-direction access counters for bench checking.

---
 rtl/iob_native_mem_ctrl.sv | 104 ++++++++++
 1 files changed

// File: rtl/iob_native_mem_ctrl.sv
// iob_native_mem_ctrl: byte-enabled word RAM answering native memory requests after a fixed latency
module iob_native_mem_ctrl #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int LATENCY   = 2,
  parameter     INIT_FILE = "none"
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                mem_valid,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W/8-1:0] mem_wstrb,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_ready,
  output logic                busy,
  output logic [31:0]         rd_cnt,
  output logic [31:0]         wr_cnt
);
  localparam int SB_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(SB_W);
  localparam int IDX_W = ADDR_W - OFF_W;
  localparam int DEPTH = 2 ** IDX_W;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  logic [1:0]        sync_q;
  logic              rst_s;
  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [SB_W-1:0]   wstrb_q, wstrb_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic [31:0]       rd_cnt_q, rd_cnt_d;
  logic [31:0]       wr_cnt_q, wr_cnt_d;
  logic              accept, fire, is_wr;
  logic              unused_ok;
  logic [DATA_W-1:0] mem [DEPTH];

  assign rst_s     = sync_q[1];
  assign unused_ok = ^mem_addr;
  assign mem_rdata = rdata_q;
  assign mem_ready = ready_q;
  assign busy      = busy_q;
  assign rd_cnt    = rd_cnt_q;
  assign wr_cnt    = wr_cnt_q;

  // reset asserts immediately, releases two clock edges later
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[0], 1'b1};

  // next-state: accept in IDLE, count down in WAIT, access on the last WAIT cycle, pulse ready in RESP
  always_comb begin
    accept   = state_q == IDLE && mem_valid;
    fire     = state_q == WAIT && cnt_q == 4'd0;
    is_wr    = |wstrb_q;
    state_d  = accept ? WAIT : fire ? RESP : state_q == RESP ? IDLE : state_q;
    cnt_d    = accept ? 4'(LATENCY - 1) : (state_q == WAIT && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
    addr_d   = accept ? mem_addr[ADDR_W-1:OFF_W] : addr_q;
    wdata_d  = accept ? mem_wdata : wdata_q;
    wstrb_d  = accept ? mem_wstrb : wstrb_q;
    rdata_d  = (fire && !is_wr) ? mem[addr_q] : rdata_q;
    ready_d  = fire;
    busy_d   = state_d != IDLE;
    rd_cnt_d = (fire && !is_wr && rd_cnt_q != '1) ? rd_cnt_q + 32'd1 : rd_cnt_q;
    wr_cnt_d = (fire && is_wr && wr_cnt_q != '1) ? wr_cnt_q + 32'd1 : wr_cnt_q;
  end

  // controller state and registered outputs
  always_ff @(posedge clk or negedge rst_s)
    if (!rst_s) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rdata_q  <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      rdata_q  <= rdata_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end

  // RAM write with per-byte enables; contents survive reset
  always_ff @(posedge clk)
    if (fire && is_wr)
      for (int b = 0; b < SB_W; b++)
        if (wstrb_q[b]) mem[addr_q][8*b +: 8] <= wdata_q[8*b +: 8];
endmodule
